zmips_wb_queue: RTL and testbench
=================================

Name: zmips_wb_queue

Overview:
Write-back initiator for the zmips register file's single write port.
- Accepts results from two producers, the ALU (single-cycle) and the memory unit (late loads), into a small in-order queue.
- Drains one entry per cycle into the regfile signals wr / wr_addr / wr_data.
- Provides a forwarding lookup so decode can read pending values before they reach the register file.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
PTR_W, $clog2(DEPTH), pointer width (derived; not overridden)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  reset; synchronous, active-high
mem_valid  input  1  memory unit presents a load result
mem_addr  input  5  destination register of load
mem_data  input  32  load data
mem_ready  output  1  queue can accept a memory result this cycle
alu_valid  input  1  ALU presents a result
alu_addr  input  5  destination register of ALU result
alu_data  input  32  ALU result
alu_ready  output  1  queue can accept an ALU result this cycle
wr  output  1  regfile write enable
wr_addr  output  5  regfile write address
wr_data  output  32  regfile write data
fwd_addr_0  input  5  forwarding lookup address, read port 0
fwd_addr_1  input  5  forwarding lookup address, read port 1
fwd_hit_0  output  1  pending write to fwd_addr_0 exists
fwd_data_0  output  32  youngest pending data for fwd_addr_0
fwd_hit_1  output  1  pending write to fwd_addr_1 exists
fwd_data_1  output  32  youngest pending data for fwd_addr_1
wb_empty  output  1  queue empty; no writes pending

Behaviour:
Storage and reset
- Circular buffer with head/tail pointers and a count in 0..DEPTH.
- On rst at a rising edge: count=0, head=tail=0; all entries are discarded, including entries in flight when reset hits mid-operation.
- Output values during reset: wr=0, wr_addr=0, wr_data=0, fwd_hit_*=0, fwd_data_*=0, wb_empty=1.

Ready flags
- Both are functions of registered count only; they never depend on any valid input.
- mem_ready = (count <= DEPTH-1).
- alu_ready = (count <= DEPTH-2).
- Together these guarantee a simultaneous double enqueue always fits.

Enqueue
- Handshake is valid & ready at a rising edge.
- If both are accepted in the same cycle, the mem entry is written at tail and the alu entry at tail+1. The load is architecturally older.
- Addresses 5'b11110 and 5'b11111 are not writable general registers. A result to either is accepted (handshake completes) but not enqueued.

Drain
- wr = (count != 0).
- wr_addr / wr_data = head entry when wr=1, otherwise 0.
- Head pops at every rising edge where wr=1; the regfile never back-pressures.
- Latency: a result accepted at edge N drives wr during cycle N..N+1 if the queue was empty, and is written into the regfile at edge N+1.

Count update
- count_next = count + (#accepted and enqueued) - pop.
- Push and pop in the same cycle are legal at every count, including full.
- Pointers wrap modulo DEPTH.

wb_empty = (count == 0).

Forwarding
- Combinational across valid entries only.
- hit when an entry address equals fwd_addr_k. data comes from the youngest matching entry, i.e. closest to tail.
- The head entry being written this cycle still counts as a hit.
- fwd_addr 30/31 never hit.

Optional Feature:
ZMIPS_WB_FWD_EN
- Defined: forwarding lookup logic is built as described above.
- Undefined: fwd_hit_* and fwd_data_* are tied to 0. No compare logic is generated. Decode must stall on wb_empty=0 instead.

Decomposition:
Shared package zmips_pkg holds:
- XLEN=32, REG_ADDR_W=5
- REG_PC_ADDR=5'b11110, REG_PCSAVE_ADDR=5'b11111
- is_writable_reg() function: true when the upper four address bits are not 1111
- wb_entry_t struct {addr, data}

Sub-module zmips_wb_fifo:
- Generic storage, pointers and count, with a two-input enqueue port and a single-output dequeue port.
- zmips_wb_queue adds the ready logic, the reg-30/31 filter and forwarding.

Test Plan:
- Reset, then ALU writes r5=0x0000_1234 with queue empty -> next cycle wr=1, wr_addr=5, wr_data=0x1234; following cycle wb_empty=1.
- Same cycle mem r3=0xAAAA_0001 and alu r3=0xBBBB_0002 -> two consecutive writes, mem first then alu; fwd_addr_0=3 returns 0xBBBB_0002 while both are pending.
- Fill: hold alu_valid every cycle plus mem_valid, DEPTH=4 -> alu_ready drops at count>=3, mem_ready drops at count=4; no entry lost or duplicated; the write sequence matches the accept order.
- alu_addr=30 with alu_valid=1 -> handshake completes, no wr pulse, fwd_addr_0=30 gives fwd_hit_0=0.
- Assert rst with 3 entries pending -> after the edge wr=0, wb_empty=1, forwarding misses; no stale write afterwards.
- Build without ZMIPS_WB_FWD_EN, pending r7 write -> fwd_hit_0=0, fwd_data_0=0 while the write still drains normally.

Source files
------------

// File: rtl/zmips_wb_queue_pkg.sv
// Shared zmips definitions used by the write-back queue: register file geometry,
// the reserved PC addresses and the queued write-back entry.
package zmips_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_PC_ADDR     = 5'b11110;
    localparam logic [REG_ADDR_W-1:0] REG_PCSAVE_ADDR = 5'b11111;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    // r30 and r31 share the upper four address bits, so one compare excludes both.
    function automatic logic is_writable_reg(input logic [REG_ADDR_W-1:0] addr);
        return addr[REG_ADDR_W-1:1] != REG_PC_ADDR[REG_ADDR_W-1:1];
    endfunction

endpackage

// File: rtl/zmips_wb_queue_if.sv
// Producer, regfile-write and forwarding signals of the zmips write-back queue.
// The master side drives results and lookup addresses; the slave side is the queue.
interface zmips_wb_queue_if;
    import zmips_pkg::*;

    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]       mem_data;
    logic                  mem_ready;

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_addr;
    logic [XLEN-1:0]       alu_data;
    logic                  alu_ready;

    logic                  wr;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [XLEN-1:0]       wr_data;

    logic [REG_ADDR_W-1:0] fwd_addr_0;
    logic [REG_ADDR_W-1:0] fwd_addr_1;
    logic                  fwd_hit_0;
    logic [XLEN-1:0]       fwd_data_0;
    logic                  fwd_hit_1;
    logic [XLEN-1:0]       fwd_data_1;

    logic                  wb_empty;

    modport master (
        output mem_valid, mem_addr, mem_data,
        output alu_valid, alu_addr, alu_data,
        output fwd_addr_0, fwd_addr_1,
        input  mem_ready, alu_ready,
        input  wr, wr_addr, wr_data,
        input  fwd_hit_0, fwd_data_0, fwd_hit_1, fwd_data_1,
        input  wb_empty
    );

    modport slave (
        input  mem_valid, mem_addr, mem_data,
        input  alu_valid, alu_addr, alu_data,
        input  fwd_addr_0, fwd_addr_1,
        output mem_ready, alu_ready,
        output wr, wr_addr, wr_data,
        output fwd_hit_0, fwd_data_0, fwd_hit_1, fwd_data_1,
        output wb_empty
    );

endinterface

// File: rtl/zmips_wb_fifo.sv
// In-order circular buffer with a two-entry enqueue port (port 0 is older) and one
// dequeue port. With ZMIPS_WB_FWD_EN defined, raw storage and head are exported for lookup.
module zmips_wb_fifo
    import zmips_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push0_i,
    input  wb_entry_t        entry0_i,
    input  logic             push1_i,
    input  wb_entry_t        entry1_i,
    input  logic             pop_i,
    output wb_entry_t        head_o,
    output logic [PTR_W:0]   count_o
`ifdef ZMIPS_WB_FWD_EN
   ,output logic [PTR_W-1:0] head_ptr_o,
    output wb_entry_t        slots_o [DEPTH]
`endif
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] tail_p1;
    logic [PTR_W:0]   count_q, count_d;
    wb_entry_t        slots_q [DEPTH];

    // Power-of-two depth lets the pointers wrap by plain overflow.
    assign tail_p1 = tail_q + PTR_ONE;

    always_comb begin
        head_d  = pop_i ? head_q + PTR_ONE : head_q;
        tail_d  = tail_q + PTR_W'(push0_i) + PTR_W'(push1_i);
        count_d = count_q + (PTR_W+1)'(push0_i) + (PTR_W+1)'(push1_i)
                - (PTR_W+1)'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: only slots inside the head..count window are ever read.
    always_ff @(posedge clk) begin
        if (push0_i) begin
            slots_q[tail_q] <= entry0_i;
        end
        if (push1_i) begin
            slots_q[push0_i ? tail_p1 : tail_q] <= entry1_i;
        end
    end

    assign head_o  = slots_q[head_q];
    assign count_o = count_q;

`ifdef ZMIPS_WB_FWD_EN
    assign head_ptr_o = head_q;
    assign slots_o    = slots_q;
`endif

endmodule

// File: rtl/zmips_wb_queue.sv
// Write-back queue for the zmips regfile write port: mem/ALU enqueue, one drain per cycle.
// Define ZMIPS_WB_FWD_EN to build the forwarding lookup; otherwise fwd outputs are 0.
module zmips_wb_queue
    import zmips_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    zmips_wb_queue_if.slave bus
);

    localparam logic [PTR_W:0] MEM_LIMIT = (PTR_W+1)'(DEPTH - 1);
    localparam logic [PTR_W:0] ALU_LIMIT = (PTR_W+1)'(DEPTH - 2);

    logic [PTR_W:0] count;
    wb_entry_t      head_entry;
    wb_entry_t      mem_entry;
    wb_entry_t      alu_entry;
    logic           mem_ready;
    logic           alu_ready;
    logic           mem_push;
    logic           alu_push;
    logic           pending;

    // Ready depends on count alone, and the ALU limit is one lower so both fit at once.
    assign mem_ready = count <= MEM_LIMIT;
    assign alu_ready = count <= ALU_LIMIT;

    // Results for r30/r31 complete the handshake but are dropped here.
    assign mem_push  = bus.mem_valid & mem_ready & is_writable_reg(bus.mem_addr);
    assign alu_push  = bus.alu_valid & alu_ready & is_writable_reg(bus.alu_addr);
    assign mem_entry = '{addr: bus.mem_addr, data: bus.mem_data};
    assign alu_entry = '{addr: bus.alu_addr, data: bus.alu_data};
    assign pending   = count != '0;

`ifdef ZMIPS_WB_FWD_EN
    logic [PTR_W-1:0] head_ptr;
    wb_entry_t        slots [DEPTH];
`endif

    zmips_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push0_i    (mem_push),
        .entry0_i   (mem_entry),
        .push1_i    (alu_push),
        .entry1_i   (alu_entry),
        .pop_i      (pending),
        .head_o     (head_entry),
        .count_o    (count)
`ifdef ZMIPS_WB_FWD_EN
       ,.head_ptr_o (head_ptr),
        .slots_o    (slots)
`endif
    );

    assign bus.mem_ready = mem_ready;
    assign bus.alu_ready = alu_ready;
    assign bus.wr        = pending & ~rst;
    assign bus.wr_addr   = bus.wr ? head_entry.addr : '0;
    assign bus.wr_data   = bus.wr ? head_entry.data : '0;
    assign bus.wb_empty  = ~pending | rst;

`ifdef ZMIPS_WB_FWD_EN
    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] hit0_vec;
    logic [DEPTH-1:0] hit1_vec;
    wb_entry_t        aged [DEPTH];

    // Index gi is age order: 0 is the head (oldest), higher gi is younger.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [PTR_W-1:0] idx;
            assign idx          = head_ptr + PTR_W'(gi);
            assign aged[gi]     = slots[idx];
            assign live[gi]     = (PTR_W+1)'(gi) < count;
            assign hit0_vec[gi] = live[gi] && (aged[gi].addr == bus.fwd_addr_0);
            assign hit1_vec[gi] = live[gi] && (aged[gi].addr == bus.fwd_addr_1);
        end
    endgenerate

    always_comb begin
        bus.fwd_hit_0  = 1'b0;
        bus.fwd_data_0 = '0;
        bus.fwd_hit_1  = 1'b0;
        bus.fwd_data_1 = '0;
        if (!rst) begin
            // Later (younger) matches overwrite earlier ones.
            for (int i = 0; i < DEPTH; i++) begin
                if (hit0_vec[i] && is_writable_reg(bus.fwd_addr_0)) begin
                    bus.fwd_hit_0  = 1'b1;
                    bus.fwd_data_0 = aged[i].data;
                end
                if (hit1_vec[i] && is_writable_reg(bus.fwd_addr_1)) begin
                    bus.fwd_hit_1  = 1'b1;
                    bus.fwd_data_1 = aged[i].data;
                end
            end
        end
    end
`else
    logic fwd_addr_unused;

    // Without forwarding, decode stalls on wb_empty; lookup addresses are ignored.
    assign fwd_addr_unused = ^{bus.fwd_addr_0, bus.fwd_addr_1};
    assign bus.fwd_hit_0   = 1'b0;
    assign bus.fwd_data_0  = '0;
    assign bus.fwd_hit_1   = 1'b0;
    assign bus.fwd_data_1  = '0;
`endif

endmodule

// File: tb/tb_zmips_wb_queue.sv
// Scoreboard bench for zmips_wb_queue: the driver queues expected regfile writes,
// a negedge monitor pops and compares every wr pulse.
module tb_zmips_wb_queue;
    import zmips_pkg::*;

    localparam int DEPTH = 4;
`ifdef ZMIPS_WB_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    wb_entry_t exp_q[$];
    wb_entry_t mon_e;

    zmips_wb_queue_if bus ();

    zmips_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Youngest pending write to a writable address, as seen by the bench's own queue.
    function automatic void model_fwd(input logic [4:0] a, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (a[4:1] != 4'hF) begin
`ifdef ZMIPS_WB_FWD_EN
            foreach (exp_q[i]) begin
                if (exp_q[i].addr == a) begin
                    hit = 1'b1;
                    d   = exp_q[i].data;
                end
            end
`endif
        end
    endfunction

    // Called at posedge+1; returns at the following posedge+1.
    task automatic cycle(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic [4:0] f0, input logic [4:0] f1);
        logic        h;
        logic [31:0] d;
        int          n;
        logic        macc;
        logic        aacc;
        bus.mem_valid  = mv;
        bus.mem_addr   = ma;
        bus.mem_data   = md;
        bus.alu_valid  = av;
        bus.alu_addr   = aa;
        bus.alu_data   = ad;
        bus.fwd_addr_0 = f0;
        bus.fwd_addr_1 = f1;
        #1;
        n = exp_q.size();
        chk("mem_ready", bus.mem_ready, n <= DEPTH - 1);
        chk("alu_ready", bus.alu_ready, n <= DEPTH - 2);
        chk("wb_empty", bus.wb_empty, n == 0);
        if (n == 0) begin
            chk("idle_wr_addr", bus.wr_addr, 0);
            chk("idle_wr_data", bus.wr_data, 0);
        end
        model_fwd(f0, h, d);
        chk("fwd_hit_0", bus.fwd_hit_0, h);
        chk("fwd_data_0", bus.fwd_data_0, d);
        model_fwd(f1, h, d);
        chk("fwd_hit_1", bus.fwd_hit_1, h);
        chk("fwd_data_1", bus.fwd_data_1, d);
        macc = mv && (n <= DEPTH - 1);
        aacc = av && (n <= DEPTH - 2);
        if (macc && ma[4:1] != 4'hF) exp_q.push_back('{addr: ma, data: md});
        if (aacc && aa[4:1] != 4'hF) exp_q.push_back('{addr: aa, data: ad});
        $display("cycle t=%0t mem=%b acc=%b r%0d alu=%b acc=%b r%0d pending=%0d",
                 $time, mv, macc, ma, av, aacc, aa, exp_q.size());
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles, input logic [4:0] f0);
        for (int i = 0; i < cycles; i++) begin
            cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, f0, 5'd0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.wr) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got r%0d=%h expected no write", bus.wr_addr, bus.wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                $display("write t=%0t r%0d=%h", $time, bus.wr_addr, bus.wr_data);
                chk("wr_addr", {27'd0, bus.wr_addr}, {27'd0, mon_e.addr});
                chk("wr_data", bus.wr_data, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.mem_valid  = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_data   = '0;
        bus.alu_valid  = 1'b0;
        bus.alu_addr   = '0;
        bus.alu_data   = '0;
        bus.fwd_addr_0 = '0;
        bus.fwd_addr_1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_wr", bus.wr, 0);
        chk("reset_wr_addr", bus.wr_addr, 0);
        chk("reset_wr_data", bus.wr_data, 0);
        chk("reset_wb_empty", bus.wb_empty, 1);
        chk("reset_fwd_hit_0", bus.fwd_hit_0, 0);
        chk("reset_fwd_data_0", bus.fwd_data_0, 0);
        rst = 1'b0;
        idle(1, 5'd0);

        // ALU r5 into an empty queue: written on the next cycle, empty the one after.
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h0000_1234, 5'd5, 5'd0);
        chk("t1_wr", bus.wr, 1);
        chk("t1_wr_addr", bus.wr_addr, 5);
        chk("t1_wr_data", bus.wr_data, 32'h0000_1234);
        idle(1, 5'd0);
        chk("t1_empty_after", bus.wb_empty, 1);

        // Same-cycle mem and ALU to r3: mem drains first, forwarding sees the ALU value.
        cycle(1'b1, 5'd3, 32'hAAAA_0001, 1'b1, 5'd3, 32'hBBBB_0002, 5'd3, 5'd3);
        chk("t2_fwd_hit", bus.fwd_hit_0, FWD_ON);
        chk("t2_fwd_data", bus.fwd_data_0, FWD_ON ? 32'hBBBB_0002 : 32'h0);
        chk("t2_first_wr", bus.wr_data, 32'hAAAA_0001);
        idle(3, 5'd3);

        // Fill pressure: both producers valid every cycle.
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 5'(8 + i), 32'h1000_0000 + i, 1'b1, 5'(16 + i), 32'h2000_0000 + i,
                  5'(8 + i), 5'(16 + i));
        end
        idle(5, 5'd9);

        // r30 from ALU and r31 from mem are accepted but never written.
        cycle(1'b1, 5'd31, 32'hDEAD_0031, 1'b1, 5'd30, 32'hDEAD_0030, 5'd30, 5'd31);
        chk("r30_no_wr", bus.wr, 0);
        chk("r30_fwd_hit", bus.fwd_hit_0, 0);
        chk("r31_fwd_hit", bus.fwd_hit_1, 0);
        idle(2, 5'd30);

        // Reset with three writes pending: all discarded, nothing stale later.
        cycle(1'b1, 5'd1, 32'h0000_0011, 1'b1, 5'd2, 32'h0000_0022, 5'd1, 5'd2);
        cycle(1'b1, 5'd4, 32'h0000_0044, 1'b1, 5'd6, 32'h0000_0066, 5'd4, 5'd6);
        chk("pre_reset_pending", exp_q.size(), 3);
        rst           = 1'b1;
        bus.mem_valid = 1'b0;
        bus.alu_valid = 1'b0;
        exp_q.delete();
        $display("reset t=%0t with pending writes", $time);
        @(posedge clk);
        #1;
        chk("mid_reset_wr", bus.wr, 0);
        chk("mid_reset_wb_empty", bus.wb_empty, 1);
        chk("mid_reset_fwd_hit_0", bus.fwd_hit_0, 0);
        rst = 1'b0;
        idle(4, 5'd4);

        // Pending r7: forwards only when the lookup is built, drains either way.
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h0000_0077, 5'd7, 5'd0);
        chk("r7_fwd_hit", bus.fwd_hit_0, FWD_ON);
        chk("r7_fwd_data", bus.fwd_data_0, FWD_ON ? 32'h0000_0077 : 32'h0);
        chk("r7_wr_addr", bus.wr_addr, 7);

        // Mem-only result followed by ALU-only.
        cycle(1'b1, 5'd12, 32'hC0DE_0012, 1'b0, 5'd0, 32'h0, 5'd12, 5'd7);
        cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 32'hC0DE_1012, 5'd12, 5'd12);
        idle(4, 5'd12);

        chk("drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
